// File: rtl/cu_ex_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states and result flags.
package cu_ex_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLL  = 6'h05;
  localparam logic [5:0] OP_SRL  = 6'h06;
  localparam logic [5:0] OP_SRA  = 6'h07;
  localparam logic [5:0] OP_SLT  = 6'h08;
  localparam logic [5:0] OP_SLTU = 6'h09;
  localparam logic [5:0] OP_BEQ  = 6'h0A;
  localparam logic [5:0] OP_BNE  = 6'h0B;
  localparam logic [5:0] OP_BLT  = 6'h0C;
  localparam logic [5:0] OP_BGE  = 6'h0D;
  localparam logic [5:0] OP_BLTU = 6'h0E;
  localparam logic [5:0] OP_BGEU = 6'h0F;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } ex_state_t;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic cond;
    logic err;
  } ex_flags_t;

endpackage

// File: rtl/ex_alu_core.sv
// Combinational ALU for the execute stage: result plus ovf/zero/cond/err flags.
module ex_alu_core
  import cu_ex_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 6
) (
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output ex_flags_t       flags_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0] sum, diff;
  logic [ShW-1:0]  shamt;
  logic            legal, lt_s, lt_u, eq;

  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign shamt = b_i[ShW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;
  // Only the low 16 codes are defined; any higher bit set is illegal.
  assign legal = (op_i >> 4) == '0;

  always_comb begin
    result_o     = '0;
    flags_o      = '0;
    if (!legal) begin
      flags_o.err = 1'b1;
    end else begin
      case (op_i[3:0])
        OP_ADD[3:0]: begin
          result_o    = sum;
          flags_o.ovf = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
        end
        OP_SUB[3:0]: begin
          result_o    = diff;
          flags_o.ovf = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
        end
        OP_AND[3:0]:  result_o = a_i & b_i;
        OP_OR[3:0]:   result_o = a_i | b_i;
        OP_XOR[3:0]:  result_o = a_i ^ b_i;
        OP_SLL[3:0]:  result_o = a_i << shamt;
        OP_SRL[3:0]:  result_o = a_i >> shamt;
        OP_SRA[3:0]:  result_o = $signed(a_i) >>> shamt;
        OP_SLT[3:0]: begin
          result_o     = {{(XLEN-1){1'b0}}, lt_s};
          flags_o.cond = lt_s;
        end
        OP_SLTU[3:0]: begin
          result_o     = {{(XLEN-1){1'b0}}, lt_u};
          flags_o.cond = lt_u;
        end
        OP_BEQ[3:0]: begin
          result_o     = diff;
          flags_o.cond = eq;
        end
        OP_BNE[3:0]: begin
          result_o     = diff;
          flags_o.cond = !eq;
        end
        OP_BLT[3:0]: begin
          result_o     = diff;
          flags_o.cond = lt_s;
        end
        OP_BGE[3:0]: begin
          result_o     = diff;
          flags_o.cond = !lt_s;
        end
        OP_BLTU[3:0]: begin
          result_o     = diff;
          flags_o.cond = lt_u;
        end
        default: begin
          result_o     = diff;
          flags_o.cond = !lt_u;
        end
      endcase
    end
    flags_o.zero = (result_o == '0);
  end

endmodule

// File: rtl/cu_ex_stage.sv
// Execute-stage controller: valid/ready issue, multi-cycle ALU timing, held result until writeback.
module cu_ex_stage
  import cu_ex_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPW     = 6,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             soc_clk,
  input  logic             EX_reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic             use_imm,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result_data,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             condition_met_flag,
  output logic             error_flag,
  output logic [CNT_W-1:0] stage_counter,
  output logic             busy
);

  ex_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  ex_flags_t       flags_q, flags_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] alu_res;
  ex_flags_t       alu_flags;
  logic            accept;

  ex_alu_core #(
    .XLEN (XLEN),
    .OPW  (OPW)
  ) u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    valid_d = valid_q;

    case (state_q)
      StIdle: ;
      StBusy: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          res_d   = alu_res;
          flags_d = alu_flags;
          valid_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accept from DONE implies out_ready, so out_valid is already dropping.
    if (accept) begin
      op_d    = op;
      a_d     = rs1_data;
      b_d     = use_imm ? imm_data : rs2_data;
      cnt_d   = '0;
      state_d = StBusy;
    end

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      res_d   = '0;
      flags_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge soc_clk or negedge EX_reset_n) begin
    if (!EX_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid          = valid_q;
  assign result_data        = res_q;
  assign overflow_flag      = flags_q.ovf;
  assign zero_flag          = flags_q.zero;
  assign condition_met_flag = flags_q.cond;
  assign error_flag         = flags_q.err;
  assign stage_counter      = cnt_q;
  assign busy               = (state_q == StBusy);

endmodule

// File: doc/cu_ex_stage.md
Name: cu_ex_stage

Overview:
- Parametrised execute-stage controller. It sits between the control unit's issue logic and writeback.
- It accepts one operation per valid/ready handshake, selects the second operand (rs2 or immediate), and runs the ALU over a configurable number of cycles.
- It holds the result and flags until writeback takes them, and supports flush plus back-to-back issue.
- This generation adds width and latency parameters, output backpressure, and a flush input.

Parameters:
- XLEN, 32, datapath width; must be a power of two, minimum 8.
- OPW, 6, opcode width.
- LATENCY, 2, cycles from accept to out_valid; legal range 1..8.
- CNT_W, $clog2(LATENCY+1), stage_counter width (derived; do not override).

Ports:
- soc_clk  in  1  stage clock.
- EX_reset_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of any in-flight or held op.
- in_valid  in  1  issue request.
- in_ready  out  1  stage can accept this cycle.
- op  in  OPW  ALU opcode (encodings in cu_ex_pkg).
- use_imm  in  1  1: operand B = imm_data; 0: operand B = rs2_data.
- rs1_data  in  XLEN  operand A.
- rs2_data  in  XLEN  register operand B.
- imm_data  in  XLEN  sign-extended immediate.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  writeback consumes the result.
- result_data  out  XLEN  registered result.
- overflow_flag  out  1  signed overflow (ADD/SUB only).
- zero_flag  out  1  result_data == 0.
- condition_met_flag  out  1  branch or compare condition true.
- error_flag  out  1  unsupported opcode.
- stage_counter  out  CNT_W  cycles elapsed in BUSY.
- busy  out  1  state == BUSY.

Behaviour:
- Reset (EX_reset_n low, asynchronous): state IDLE; out_valid, all flags, result_data, stage_counter and busy = 0. in_ready = 1 once reset is released.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (IDLE) or (DONE and out_ready). in_ready is combinational and never depends on in_valid.
- Accept event: in_valid and in_ready on a rising edge.
  - Latches op, A, and B (already muxed by use_imm).
  - stage_counter <= 0; next state BUSY.
- BUSY:
  - stage_counter increments each cycle.
  - At the edge where stage_counter == LATENCY-1: register result_data and all flags, computed from the latched operands; set out_valid = 1; go to DONE.
  - With LATENCY=1, out_valid rises on the first edge after accept.
  - With LATENCY=N, out_valid rises N edges after the accept edge.
- DONE:
  - Outputs hold stable while out_ready = 0.
  - out_ready = 1 with no accept: go to IDLE, out_valid = 0.
  - out_ready = 1 with accept in the same cycle: go to BUSY with the new op, out_valid = 0. This gives a throughput of one op per LATENCY+1 cycles.
- flush:
  - Takes priority over everything, including a same-cycle accept, which is dropped.
  - Next state IDLE; out_valid, flags and stage_counter cleared; result_data cleared to 0.
  - Since in_ready does not see flush, the issuer must not count an accept made during a flush cycle.
- Arithmetic:
  - Ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Results wrap modulo 2^XLEN.
  - Shift amount = B[$clog2(XLEN)-1:0]; upper bits are ignored.
  - SLT/SLTU: result = {XLEN-1 zeros, cond}; condition_met_flag = cond.
  - Branches: result = A - B; condition_met_flag = branch outcome; overflow_flag = 0.
  - overflow_flag: ADD = A and B same sign and result sign differs. SUB = A and B signs differ and result sign differs from A.
- Unsupported opcode:
  - Completes through the normal latency.
  - result_data = 0, error_flag = 1, all other flags 0 except zero_flag = 1.
- Operand inputs are ignored except on the accept edge.

Decomposition:
- cu_ex_pkg holds:
  - the opcode localparams (OP_ADD=6'h00 ... OP_BGEU=6'h0F; all other codes illegal);
  - the state enum typedef ex_state_t;
  - a flags struct typedef {ovf, zero, cond, err}.
- One sub-module, ex_alu_core: purely combinational, parametrised by XLEN/OPW. Inputs op, A, B; outputs result and flags struct.
- cu_ex_stage owns the FSM, the counter, the operand and result registers, and the handshake.

Test Plan:
- Reset mid-BUSY (LATENCY=3, assert EX_reset_n=0 at stage_counter=1) -> all outputs 0 immediately; in_ready=1 after release; no stale out_valid.
- LATENCY=2: accept ADD A=32'h7FFFFFFF, B=rs2=1, use_imm=0 -> out_valid exactly 2 edges after accept; result 32'h80000000, overflow_flag=1, zero_flag=0.
- Backpressure: SUB A=5, imm=5, use_imm=1, out_ready=0 for 4 cycles -> result 0, zero_flag=1, outputs stable; in_ready=0 until out_ready=1.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (BLTU A=1, B=32'hFFFFFFFF) -> accepted the same cycle; next result condition_met_flag=1, result 32'h00000002.
- Flush collision: flush=1 with in_valid=1 while in DONE -> IDLE, out_valid=0, op dropped; the next cycle accepts normally.
- Illegal op 6'h3F, and SRA A=32'h80000000 with B=32'h00000024 (shift 4) -> illegal op gives error_flag=1, result 0. SRA gives 32'hF8000000, error_flag=0.
